// File: rtl/branch_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_control_unit
// Description : Control-step sequencer for instruction fetch and the
//               branch/jump family (br, jr, jal), nop and halt. Datapath
//               control strobes come from the registered state. Two
//               exceptions read inputs in the current cycle: T3 decodes the
//               live opcode, and the br T6 PC load is gated by CON_out.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] IR_Data,
    input  logic        CON_out,
    output logic        PC_out,
    output logic        PC_in,
    output logic        IncPC,
    output logic        MAR_in,
    output logic        MDR_in,
    output logic        MDR_out,
    output logic        IR_in,
    output logic        Y_in,
    output logic        Z_in,
    output logic        Zlow_out,
    output logic        C_out,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Rout,
    output logic        CON_in,
    output logic [15:0] RX_in_man,
    output logic [4:0]  alu_instruction_bits,
    output logic        halted,
    output logic        illegal_op
);

    localparam logic [4:0]  c_OP_BR   = 5'b10011;
    localparam logic [4:0]  c_OP_JR   = 5'b10100;
    localparam logic [4:0]  c_OP_JAL  = 5'b10101;
    localparam logic [4:0]  c_OP_NOP  = 5'b11010;
    localparam logic [4:0]  c_OP_HALT = 5'b11011;
    localparam logic [4:0]  c_ALU_ADD = 5'b00011;
    localparam logic [15:0] c_SEL_R15 = 16'h8000;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_op;
    logic [4:0] w_opcode;
    logic       w_unused_ir;

    assign w_opcode    = IR_Data[31:27];
    // Only the opcode field matters to this block.
    assign w_unused_ir = ^IR_Data[26:0];

    // State register; clr forces IDLE from any state, including HALT.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Keep the opcode decoded in T3 so that T4..T6 know which instruction is running.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_op <= 5'd0;
        end else if (r_state == S_T3) begin
            r_op <= w_opcode;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = run ? S_T0 : S_IDLE;
            S_T0:   w_next = S_T1;
            S_T1:   w_next = S_T2;
            S_T2:   w_next = S_T3;
            S_T3: begin
                case (w_opcode)
                    c_OP_BR:   w_next = S_T4;
                    c_OP_JAL:  w_next = S_T4;
                    c_OP_HALT: w_next = S_HALT;
                    default:   w_next = S_T0;
                endcase
            end
            S_T4:   w_next = (r_op == c_OP_BR) ? S_T5 : S_T0;
            S_T5:   w_next = S_T6;
            S_T6:   w_next = S_T0;
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode; every strobe defaults low and is raised only in its step.
    always_comb begin
        PC_out               = 1'b0;
        PC_in                = 1'b0;
        IncPC                = 1'b0;
        MAR_in               = 1'b0;
        MDR_in               = 1'b0;
        MDR_out              = 1'b0;
        IR_in                = 1'b0;
        Y_in                 = 1'b0;
        Z_in                 = 1'b0;
        Zlow_out             = 1'b0;
        C_out                = 1'b0;
        Read                 = 1'b0;
        Gra                  = 1'b0;
        Grb                  = 1'b0;
        Rout                 = 1'b0;
        CON_in               = 1'b0;
        RX_in_man            = 16'd0;
        alu_instruction_bits = 5'd0;
        halted               = 1'b0;
        illegal_op           = 1'b0;
        case (r_state)
            S_T0: begin
                PC_out = 1'b1;
                MAR_in = 1'b1;
                IncPC  = 1'b1;
                Z_in   = 1'b1;
            end
            S_T1: begin
                Zlow_out = 1'b1;
                PC_in    = 1'b1;
                Read     = 1'b1;
                MDR_in   = 1'b1;
            end
            S_T2: begin
                MDR_out = 1'b1;
                IR_in   = 1'b1;
            end
            S_T3: begin
                case (w_opcode)
                    c_OP_BR: begin
                        Grb    = 1'b1;
                        Rout   = 1'b1;
                        CON_in = 1'b1;
                    end
                    c_OP_JR: begin
                        Gra   = 1'b1;
                        Rout  = 1'b1;
                        PC_in = 1'b1;
                    end
                    c_OP_JAL: begin
                        PC_out    = 1'b1;
                        RX_in_man = c_SEL_R15;
                    end
                    c_OP_NOP, c_OP_HALT: begin
                    end
                    default: illegal_op = 1'b1;
                endcase
            end
            S_T4: begin
                if (r_op == c_OP_BR) begin
                    PC_out = 1'b1;
                    Y_in   = 1'b1;
                end else begin
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    PC_in = 1'b1;
                end
            end
            S_T5: begin
                C_out                = 1'b1;
                Z_in                 = 1'b1;
                alu_instruction_bits = c_ALU_ADD;
            end
            S_T6: begin
                Zlow_out = 1'b1;
                PC_in    = CON_out;
            end
            S_HALT: halted = 1'b1;
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_control_unit
// Description : Directed self-checking bench for branch_control_unit. Each
//               step pushes the outputs expected after the next clock edge
//               and pops them for comparison once that edge has passed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_control_unit;

    logic        clk;
    logic        clr;
    logic        run;
    logic [31:0] IR_Data;
    logic        CON_out;
    logic        PC_out, PC_in, IncPC, MAR_in, MDR_in, MDR_out, IR_in, Y_in;
    logic        Z_in, Zlow_out, C_out, Read, Gra, Grb, Rout, CON_in;
    logic [15:0] RX_in_man;
    logic [4:0]  alu_instruction_bits;
    logic        halted;
    logic        illegal_op;

    int vectors;
    int miscompares;

    typedef struct {
        string       tag;
        logic [38:0] exp;
    } sb_t;
    sb_t sb_q[$];

    // Output vector layout (MSB first): PC_out PC_in IncPC MAR_in MDR_in
    // MDR_out IR_in Y_in Z_in Zlow_out C_out Read Gra Grb Rout CON_in
    // RX_in_man[15:0] alu[4:0] halted illegal_op
    localparam logic [38:0] B_PC_OUT  = 39'd1 << 38;
    localparam logic [38:0] B_PC_IN   = 39'd1 << 37;
    localparam logic [38:0] B_INCPC   = 39'd1 << 36;
    localparam logic [38:0] B_MAR_IN  = 39'd1 << 35;
    localparam logic [38:0] B_MDR_IN  = 39'd1 << 34;
    localparam logic [38:0] B_MDR_OUT = 39'd1 << 33;
    localparam logic [38:0] B_IR_IN   = 39'd1 << 32;
    localparam logic [38:0] B_Y_IN    = 39'd1 << 31;
    localparam logic [38:0] B_Z_IN    = 39'd1 << 30;
    localparam logic [38:0] B_ZLOW    = 39'd1 << 29;
    localparam logic [38:0] B_C_OUT   = 39'd1 << 28;
    localparam logic [38:0] B_READ    = 39'd1 << 27;
    localparam logic [38:0] B_GRA     = 39'd1 << 26;
    localparam logic [38:0] B_GRB     = 39'd1 << 25;
    localparam logic [38:0] B_ROUT    = 39'd1 << 24;
    localparam logic [38:0] B_CON_IN  = 39'd1 << 23;
    localparam logic [38:0] B_R15     = 39'h0000008000 << 7;
    localparam logic [38:0] B_ADD     = 39'd3 << 2;
    localparam logic [38:0] B_HALTED  = 39'd1 << 1;
    localparam logic [38:0] B_ILLEGAL = 39'd1;

    localparam logic [38:0] E_IDLE   = 39'd0;
    localparam logic [38:0] E_T0     = B_PC_OUT | B_MAR_IN | B_INCPC | B_Z_IN;
    localparam logic [38:0] E_T1     = B_ZLOW | B_PC_IN | B_READ | B_MDR_IN;
    localparam logic [38:0] E_T2     = B_MDR_OUT | B_IR_IN;
    localparam logic [38:0] E_BR_T3  = B_GRB | B_ROUT | B_CON_IN;
    localparam logic [38:0] E_BR_T4  = B_PC_OUT | B_Y_IN;
    localparam logic [38:0] E_BR_T5  = B_C_OUT | B_Z_IN | B_ADD;
    localparam logic [38:0] E_JUMP   = B_GRA | B_ROUT | B_PC_IN;
    localparam logic [38:0] E_JAL_T3 = B_PC_OUT | B_R15;

    localparam logic [31:0] IR_BR   = {5'b10011, 27'h5A5A5A5};
    localparam logic [31:0] IR_JR   = {5'b10100, 27'h0123456};
    localparam logic [31:0] IR_JAL  = {5'b10101, 27'h7FFFFFF};
    localparam logic [31:0] IR_NOP  = {5'b11010, 27'h0000000};
    localparam logic [31:0] IR_HALT = {5'b11011, 27'h1111111};
    localparam logic [31:0] IR_ILL  = {5'b11111, 27'h2222222};

    branch_control_unit dut (
        .clk                  (clk),
        .clr                  (clr),
        .run                  (run),
        .IR_Data              (IR_Data),
        .CON_out              (CON_out),
        .PC_out               (PC_out),
        .PC_in                (PC_in),
        .IncPC                (IncPC),
        .MAR_in               (MAR_in),
        .MDR_in               (MDR_in),
        .MDR_out              (MDR_out),
        .IR_in                (IR_in),
        .Y_in                 (Y_in),
        .Z_in                 (Z_in),
        .Zlow_out             (Zlow_out),
        .C_out                (C_out),
        .Read                 (Read),
        .Gra                  (Gra),
        .Grb                  (Grb),
        .Rout                 (Rout),
        .CON_in               (CON_in),
        .RX_in_man            (RX_in_man),
        .alu_instruction_bits (alu_instruction_bits),
        .halted               (halted),
        .illegal_op           (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [38:0] observed();
        return {PC_out, PC_in, IncPC, MAR_in, MDR_in, MDR_out, IR_in, Y_in,
                Z_in, Zlow_out, C_out, Read, Gra, Grb, Rout, CON_in,
                RX_in_man, alu_instruction_bits, halted, illegal_op};
    endfunction

    // Drive inputs, queue the expected outputs for after the next edge,
    // clock once, then pop and compare one cycle-settled sample.
    task automatic step(input string tag, input logic s_clr, input logic s_run,
                        input logic [31:0] s_ir, input logic s_con,
                        input logic [38:0] exp);
        sb_t e;
        logic [38:0] got;
        clr     = s_clr;
        run     = s_run;
        IR_Data = s_ir;
        CON_out = s_con;
        sb_q.push_back('{tag, exp});
        @(posedge clk);
        #1;
        e   = sb_q.pop_front();
        got = observed();
        vectors++;
        assert (got === e.exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", e.tag, got, e.exp);
        end
    endtask

    // Fetch from T0 (already entered); run is low to show it is ignored mid-instruction.
    task automatic fetch(input logic [31:0] ir);
        step("T1", 1'b0, 1'b0, ir, 1'b0, E_T1);
        step("T2", 1'b0, 1'b0, ir, 1'b0, E_T2);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clr = 1'b1; run = 1'b0; IR_Data = 32'd0; CON_out = 1'b0;
        #2;

        step("reset",          1'b1, 1'b0, IR_BR, 1'b0, E_IDLE);
        step("clr_over_run",   1'b1, 1'b1, IR_BR, 1'b1, E_IDLE);
        step("idle_hold",      1'b0, 1'b0, IR_BR, 1'b1, E_IDLE);
        step("idle_to_T0",     1'b0, 1'b1, IR_BR, 1'b0, E_T0);

        // br, CON_out high everywhere except T6: PC must not load
        fetch(IR_BR);
        step("br_T3",          1'b0, 1'b0, IR_BR, 1'b1, E_BR_T3);
        step("br_T4",          1'b0, 1'b0, IR_BR, 1'b1, E_BR_T4);
        step("br_T5",          1'b0, 1'b0, IR_BR, 1'b1, E_BR_T5);
        step("br_T6_notaken",  1'b0, 1'b0, IR_BR, 1'b0, B_ZLOW);
        step("br_back_T0",     1'b0, 1'b0, IR_BR, 1'b1, E_T0);

        // br taken
        fetch(IR_BR);
        step("brt_T3",         1'b0, 1'b0, IR_BR, 1'b0, E_BR_T3);
        step("brt_T4",         1'b0, 1'b0, IR_BR, 1'b0, E_BR_T4);
        step("brt_T5_add",     1'b0, 1'b0, IR_BR, 1'b0, E_BR_T5);
        step("brt_T6_taken",   1'b0, 1'b0, IR_BR, 1'b1, B_ZLOW | B_PC_IN);
        step("brt_back_T0",    1'b0, 1'b0, IR_BR, 1'b0, E_T0);

        // jal
        fetch(IR_JAL);
        step("jal_T3",         1'b0, 1'b0, IR_JAL, 1'b1, E_JAL_T3);
        step("jal_T4",         1'b0, 1'b0, IR_JAL, 1'b1, E_JUMP);
        step("jal_back_T0",    1'b0, 1'b0, IR_JAL, 1'b0, E_T0);

        // jr
        fetch(IR_JR);
        step("jr_T3",          1'b0, 1'b0, IR_JR, 1'b0, E_JUMP);
        step("jr_back_T0",     1'b0, 1'b0, IR_JR, 1'b0, E_T0);

        // nop
        fetch(IR_NOP);
        step("nop_T3",         1'b0, 1'b0, IR_NOP, 1'b1, E_IDLE);
        step("nop_back_T0",    1'b0, 1'b0, IR_NOP, 1'b0, E_T0);

        // illegal opcode: one-cycle pulse then T0
        fetch(IR_ILL);
        step("ill_T3_pulse",   1'b0, 1'b0, IR_ILL, 1'b0, B_ILLEGAL);
        step("ill_back_T0",    1'b0, 1'b0, IR_ILL, 1'b0, E_T0);

        // clr in br T5: IDLE on that edge, everything low
        fetch(IR_BR);
        step("clrbr_T3",       1'b0, 1'b0, IR_BR, 1'b0, E_BR_T3);
        step("clrbr_T4",       1'b0, 1'b0, IR_BR, 1'b0, E_BR_T4);
        step("clrbr_T5",       1'b0, 1'b0, IR_BR, 1'b0, E_BR_T5);
        step("clrbr_idle",     1'b1, 1'b1, IR_BR, 1'b1, E_IDLE);
        step("clrbr_stay",     1'b0, 1'b0, IR_BR, 1'b0, E_IDLE);

        // clr mid-fetch
        step("mf_T0",          1'b0, 1'b1, IR_BR, 1'b0, E_T0);
        step("mf_clr_idle",    1'b1, 1'b0, IR_BR, 1'b0, E_IDLE);

        // halt: stays halted with run held high, until clr
        step("h_T0",           1'b0, 1'b1, IR_HALT, 1'b0, E_T0);
        step("h_T1",           1'b0, 1'b1, IR_HALT, 1'b0, E_T1);
        step("h_T2",           1'b0, 1'b1, IR_HALT, 1'b0, E_T2);
        step("h_T3",           1'b0, 1'b1, IR_HALT, 1'b0, E_IDLE);
        for (int i = 0; i < 10; i++) begin
            step("halt_hold",  1'b0, 1'b1, IR_HALT, i[0], B_HALTED);
        end
        step("halt_clr",       1'b1, 1'b1, IR_HALT, 1'b0, E_IDLE);
        step("post_halt_run",  1'b0, 1'b1, IR_NOP,  1'b0, E_T0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_control_unit.md
BRANCH_CONTROL_UNIT -- requirements
Module: branch_control_unit

Interface
REQ-001 SHALL have the port `clk`, input, 1 bit: the system clock; all state changes occur on its rising edge.
REQ-002 SHALL have the port `clr`, input, 1 bit: the reset, which is synchronous and active-high.
REQ-003 SHALL have the port `run`, input, 1 bit: when high, the block leaves IDLE and begins instruction fetch.
REQ-004 SHALL have the port `IR_Data`, input, 32 bits: the current instruction; the opcode is `IR_Data[31:27]`.
REQ-005 SHALL have the port `CON_out`, input, 1 bit: the branch condition result from the CON FF logic.
REQ-006 SHALL have the following datapath control outputs, each 1 bit: `PC_out`, `PC_in`, `IncPC`, `MAR_in`, `MDR_in`, `MDR_out`, `IR_in`, `Y_in`, `Z_in`, `Zlow_out`, `C_out`, `Read`, `Gra`, `Grb`, `Rout`, `CON_in`.
REQ-007 SHALL have the port `RX_in_man`, output, 16 bits: manual register-load select; bit 15 selects R15.
REQ-008 SHALL have the port `alu_instruction_bits`, output, 5 bits: the ALU operation code.
REQ-009 SHALL have the port `halted`, output, 1 bit: high while in the HALT state.
REQ-010 SHALL have the port `illegal_op`, output, 1 bit: a one-cycle pulse on an unsupported opcode.

Function
REQ-011 SHALL be a Moore FSM; every output SHALL be decoded from the registered state only, and SHALL be 0 in any state that does not list it.
REQ-012 SHALL have the states IDLE, T0, T1, T2, T3, T4, T5, T6, HALT, and each T-state SHALL last exactly one clock cycle.
REQ-013 SHALL, in IDLE, go to T0 when `run`=1 and otherwise remain in IDLE.
REQ-014 SHALL, in T0, assert `PC_out`, `MAR_in`, `IncPC` and `Z_in`, then go to T1.
REQ-015 SHALL, in T1, assert `Zlow_out`, `PC_in`, `Read` and `MDR_in`, then go to T2.
REQ-016 SHALL, in T2, assert `MDR_out` and `IR_in`, then go to T3.
REQ-017 SHALL, in T3, decode the opcode from `IR_Data` sampled during T3.
REQ-018 SHALL handle br (10011):
  - T3: assert `Grb`, `Rout`, `CON_in`.
  - T4: assert `PC_out`, `Y_in`.
  - T5: assert `C_out`, `Z_in`, and `alu_instruction_bits`=00011 (ADD).
  - T6: assert `Zlow_out`; assert `PC_in` only if `CON_out`=1 during T6.
  - Then go to T0.
REQ-019 SHALL handle jr (10100): in T3, assert `Gra`, `Rout`, `PC_in`, then go to T0.
REQ-020 SHALL handle jal (10101):
  - T3: assert `PC_out` and `RX_in_man`=16'h8000.
  - T4: assert `Gra`, `Rout`, `PC_in`.
  - Then go to T0.
REQ-021 SHALL handle nop (11010): in T3, assert no outputs, then go to T0.
REQ-022 SHALL handle halt (11011): T3 SHALL go to HALT; in HALT, `halted`=1, and the block SHALL remain in HALT until `clr`; `run` SHALL be ignored there.
REQ-023 SHALL, for any other opcode, pulse `illegal_op` for one cycle in T3, assert no other outputs, and go to T0.
REQ-024 SHALL sample `CON_out` only in T6 of br; its value in any other state SHALL have no effect.
REQ-025 SHALL honour `run` only in IDLE; deasserting `run` mid-instruction SHALL NOT abort the instruction.
REQ-026 SHALL keep `RX_in_man`=0 in all states except jal T3.
REQ-027 SHALL keep `alu_instruction_bits`=0 in all states except br T5.

Reset
REQ-028 SHALL, when `clr`=1 at a rising edge, put the FSM in IDLE at that edge regardless of the current state, including mid-fetch, mid-branch and HALT.
REQ-029 SHALL drive every output to 0 while in IDLE, including `halted`=0, `illegal_op`=0, `RX_in_man`=0 and `alu_instruction_bits`=0.
REQ-030 SHALL give `clr` priority over `run`; if both are high, the state after the edge SHALL be IDLE.

Verification
REQ-031 SHALL pass this scenario: `clr` for 1 cycle, then `run`=1 → the next edges step IDLE→T0→T1→T2, with T0 showing `PC_out`=`MAR_in`=`IncPC`=`Z_in`=1 and T1 showing `Read`=1.
REQ-032 SHALL pass this scenario: `IR_Data`=br opcode 10011, `CON_out`=0 in T6 → T6 has `Zlow_out`=1 and `PC_in`=0, and the state after T6 is T0.
REQ-033 SHALL pass this scenario: the same br with `CON_out`=1 in T6 → T6 has `Zlow_out`=1 and `PC_in`=1; T5 has `alu_instruction_bits`=00011.
REQ-034 SHALL pass this scenario: jal (10101) → T3 has `PC_out`=1 and `RX_in_man`=16'h8000; T4 has `Gra`=`Rout`=`PC_in`=1; then T0.
REQ-035 SHALL pass this scenario: halt (11011) → HALT with `halted`=1 held for 10 cycles with `run`=1; then `clr`=1 → IDLE and `halted`=0.
REQ-036 SHALL pass this scenario: opcode 11111 → `illegal_op`=1 for exactly one cycle, then T0; separately, `clr` asserted in br T5 → IDLE on that edge with all outputs 0.
